// File: rtl/core_pkg.sv
// Shared constants for the MIPS-subset core: reset vector, NOP encoding,
// redirect op codes and the instruction-memory image.
package core_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   localparam logic [1:0] REDIR_NONE = 2'b00;
   localparam logic [1:0] REDIR_REL  = 2'b01;
   localparam logic [1:0] REDIR_ABS  = 2'b10;
   localparam logic [1:0] REDIR_REG  = 2'b11;

   // Boot image as a pure function of the word index, so the ROM
   // needs no memory-initialisation file.
   function automatic logic [31:0] im_init_word(input logic [31:0] idx);
      return 32'hA5A5_0000 ^ idx;
   endfunction

endpackage

// File: rtl/ifu_pipe_im_rom.sv
// Word-addressed instruction ROM with a combinational read port.
import core_pkg::*;

module im_rom #(
   parameter int AW = 10
) (
   input  logic [AW-3:0] addr,
   output logic [31:0]   data
);

   assign data = im_init_word(32'(addr));

endmodule

// File: rtl/ifu_pipe.sv
// Instruction-fetch stage: PC register, redirect target selection,
// ROM window check and the IF/ID pipeline register.
import core_pkg::*;

module ifu_pipe #(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          IM_AW     = 10,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  redir_op,
   input  logic [31:0] redir_pc,
   input  logic [25:0] redir_imm,
   input  logic [31:0] redir_rs,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic        id_fault,
   output logic [31:0] fetch_cnt
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] offset;
   logic [31:0] rel_off;
   logic [31:0] target;
   logic [31:0] rom_data;
   logic        fetch_bad;
   logic        redir_active;

   assign pc_plus4 = pc + 32'd4;
   assign offset   = pc - RESET_PC;

   // A pc below the window wraps to a huge offset, so one offset test
   // covers both bounds; RESET_PC is word aligned so offset[1:0] == pc[1:0].
   assign fetch_bad = (offset[1:0] != 2'b00) || (offset[31:IM_AW] != '0);

   im_rom #(.AW(IM_AW)) u_rom (
      .addr (offset[IM_AW-1:2]),
      .data (rom_data)
   );

   assign rel_off      = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
   assign redir_active = (redir_op != REDIR_NONE);

   always_comb begin
      target = redir_rs;
      case (redir_op)
         REDIR_REL: target = redir_pc + 32'd4 + rel_off;
         REDIR_ABS: target = {redir_pc[31:28], redir_imm, 2'b00};
         default:   target = redir_rs;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         id_instr  <= NOP_INSTR;
         id_pc     <= RESET_PC;
         id_pc4    <= RESET_PC + 32'd4;
         id_valid  <= 1'b0;
         id_fault  <= 1'b0;
         fetch_cnt <= '0;
      end else if (redir_active) begin
         // Redirect beats stall; the instruction fetched this cycle is dropped.
         pc       <= target;
         id_instr <= NOP_INSTR;
         id_valid <= 1'b0;
         id_fault <= 1'b0;
      end else if (!stall) begin
         pc       <= pc_plus4;
         id_pc    <= pc;
         id_pc4   <= pc_plus4;
         id_valid <= 1'b1;
         if (fetch_bad) begin
            id_instr <= NOP_INSTR;
            id_fault <= 1'b1;
         end else begin
            id_instr  <= rom_data;
            id_fault  <= 1'b0;
            fetch_cnt <= fetch_cnt + 32'd1;
         end
      end
   end

endmodule
